pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencing with a 2-entry {instr, PC} fetch queue; define FETCH_BYPASS_EN for same-cycle empty-queue bypass
module pc_fetch_unit #(
    parameter int PC_W    = 48,
    parameter int INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [PC_W-1:0]    PCResult,
    output logic [PC_W-1:0]    PCNext,
    output logic               PCen,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    RedirectTarget,
    output logic               MemReq,
    output logic [PC_W-1:0]    MemAddr,
    input  logic               MemAck,
    input  logic [INSTR_W-1:0] MemData,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    InstrPC,
    input  logic               InstrReady
);
    typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;
    state_t state, state_next;
    logic [INSTR_W-1:0] q_instr [2];
    logic [PC_W-1:0]    q_pc [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count, count_next;
    logic [PC_W-1:0]    addr_q;
    logic               ack_req, push, pop, bypass, has_head;
    assign ack_req  = state == REQ && MemAck && !Redirect;
`ifdef FETCH_BYPASS_EN
    assign bypass   = ack_req && count == 2'd0;
`else
    assign bypass   = 1'b0;
`endif
    assign has_head = count != 2'd0;
    assign pop      = has_head && InstrReady;
    // a bypassed word that decode takes immediately never enters the queue
    assign push       = ack_req && !(bypass && InstrReady);
    assign count_next = Redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ:  state_next = Redirect ? (MemAck ? REQ : DROP) : (ack_req && count_next == 2'd2) ? FULL : REQ;
            FULL: state_next = count_next < 2'd2 ? REQ : FULL;
            DROP: state_next = (!Redirect && MemAck) ? REQ : DROP;
        endcase
        MemReq     = !Reset && (state == REQ || state == DROP);
        MemAddr    = Reset ? '0 : state == REQ ? PCResult : state == DROP ? addr_q : '0;
        PCen       = !Reset && (Redirect || ack_req);
        PCNext     = Reset ? '0 : Redirect ? RedirectTarget : ack_req ? PCResult + PC_W'(1) : PCResult;
        InstrValid = !Reset && (has_head || bypass);
        Instr      = Reset ? '0 : has_head ? q_instr[rd_ptr] : bypass ? MemData : '0;
        InstrPC    = Reset ? '0 : has_head ? q_pc[rd_ptr] : bypass ? PCResult : '0;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == REQ)
                addr_q <= PCResult;
            if (Redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= !wr_ptr;
                if (pop)
                    rd_ptr <= !rd_ptr;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            q_instr[wr_ptr] <= MemData;
            q_pc[wr_ptr]    <= PCResult;
        end
    end
endmodule
